bht_update_queue: RTL and testbench
===================================

Name: bht_update_queue

Overview:
- Producer side of the branch-predictor update interface. Sits in execute, between the branch unit and the global branch predictor.
- Accepts resolved conditional branches with their prediction metadata and buffers them in a small FIFO.
- Drains one update per handshake to the predictor as valid / pc / taken / index.
- Flags mispredictions and suppresses training while in debug mode.

Parameters:
- VLEN, 64, virtual PC width.
- INDEX_BITS, 9, width of the predictor row-index metadata carried with each branch.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous, active-low
- flush_bp_i  in  1  branch-predictor flush; empties the queue
- debug_mode_i  in  1  core is in debug mode
- res_valid_i  in  1  resolved branch valid
- res_ready_o  out  1  queue can accept a resolved branch
- res_pc_i  in  VLEN  branch PC
- res_taken_i  in  1  actual outcome
- res_pred_taken_i  in  1  outcome predicted at fetch
- res_index_i  in  INDEX_BITS  predictor index captured at fetch
- upd_valid_o  out  1  update available to the predictor
- upd_ready_i  in  1  predictor accepts the update
- upd_pc_o  out  VLEN  head-entry PC
- upd_taken_o  out  1  head-entry outcome
- upd_index_o  out  INDEX_BITS  head-entry index
- mispredict_o  out  1  one-cycle pulse on an accepted mispredicted branch
- mispred_cnt_o  out  CNT_W  mispredicted-branch count (statistics only)
- branch_cnt_o  out  CNT_W  accepted-branch count (statistics only)

Behaviour:
- Reset values: all outputs 0 except res_ready_o = 1; FIFO empty; read and write pointers 0.
- Storage: circular FIFO with read/write pointers of $clog2(DEPTH)+1 bits. The extra MSB separates full from empty. Pointers wrap modulo 2*DEPTH.
- res_ready_o = !full || (upd_valid_o && upd_ready_i). A push into a full FIFO is legal when a pop happens in the same cycle.
- Accept = res_valid_i && res_ready_o.
- On accept with debug_mode_i = 0: write {pc, taken, index} at the write pointer and advance it.
- On accept with debug_mode_i = 1: complete the handshake but discard the entry. No push, no pulse, no count.
- upd_valid_o = !empty. The upd_* data outputs come from the head entry, read combinationally from registered storage.
- Pop = upd_valid_o && upd_ready_i; advance the read pointer.
- Latency: a branch accepted in cycle N appears on upd_valid_o in cycle N+1 at the earliest. There is no same-cycle bypass.
- Simultaneous push and pop:
  - Occupancy is unchanged.
  - Full plus push plus pop stays full.
  - Empty plus push: no pop is possible that cycle, since upd_valid_o = 0.
- While upd_ready_i = 0, the head entry and all upd_* outputs stay stable.
- mispredict_o: registered. High in cycle N+1 iff a non-debug accept in cycle N had res_taken_i != res_pred_taken_i. It is independent of FIFO drain.
- flush_bp_i:
  - Synchronous. Next cycle, both pointers = 0 and upd_valid_o = 0.
  - Any accept in the flush cycle is discarded.
  - mispredict_o is still generated for that accept.
  - Statistics counters are not cleared.
- Reset asserted mid-operation clears the FIFO and all outputs immediately (asynchronously).

Optional Feature:
- Macro: BHT_UPDATE_QUEUE_STATS_EN.
- Defined:
  - branch_cnt_o increments on every non-debug accept.
  - mispred_cnt_o increments on every accepted mispredict.
  - Both saturate at 2^CNT_W-1 and reset to 0 only on rst_ni.
- Undefined: both counters are absent and the ports are tied to 0.

Test Plan:
- Reset, then one branch: pc=0x8000_0010, taken=1, pred=1, index=0x05, upd_ready_i=1. Expect upd_valid_o=1 one cycle later with pc=0x8000_0010, taken=1, index=0x05; mispredict_o stays 0.
- upd_ready_i=0, push 5 branches with DEPTH=4. Expect 4 accepted and res_ready_o=0 on the 5th. Raise upd_ready_i: 4 updates drain in FIFO order and res_ready_o returns to 1.
- Full FIFO, res_valid_i=1 and upd_ready_i=1 in the same cycle. Expect accept and pop together, occupancy stays 4, and data order is preserved across pointer wrap.
- Branch with taken=0, pred=1. Expect mispredict_o=1 for exactly one cycle; with STATS_EN, mispred_cnt_o=1 and branch_cnt_o=1.
- debug_mode_i=1 with 3 branches pushed. Expect res_ready_o=1, upd_valid_o stays 0, no mispredict pulse, counters unchanged.
- Queue holds 3 entries, assert flush_bp_i for one cycle. Expect upd_valid_o=0 next cycle; a following push emerges as the only update.

Source files
------------

// File: rtl/bht_update_queue.sv
// bht_update_queue: buffers resolved conditional branches from the branch unit
// and drains them one per handshake to the global branch predictor.
// Optional statistics counters are built when BHT_UPDATE_QUEUE_STATS_EN is
// defined; otherwise branch_cnt_o / mispred_cnt_o are tied to zero.
module bht_update_queue #(
  parameter int unsigned VLEN       = 64,
  parameter int unsigned INDEX_BITS = 9,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_bp_i,
  input  logic                  debug_mode_i,
  input  logic                  res_valid_i,
  output logic                  res_ready_o,
  input  logic [VLEN-1:0]       res_pc_i,
  input  logic                  res_taken_i,
  input  logic                  res_pred_taken_i,
  input  logic [INDEX_BITS-1:0] res_index_i,
  output logic                  upd_valid_o,
  input  logic                  upd_ready_i,
  output logic [VLEN-1:0]       upd_pc_o,
  output logic                  upd_taken_o,
  output logic [INDEX_BITS-1:0] upd_index_o,
  output logic                  mispredict_o,
  output logic [CNT_W-1:0]      mispred_cnt_o,
  output logic [CNT_W-1:0]      branch_cnt_o
);

  // Pointers carry one extra MSB so that full and empty are distinguishable.
  localparam int unsigned PTR_W = $clog2(DEPTH) + 1;
  localparam int unsigned AW    = PTR_W - 1;

  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [VLEN-1:0]       r_pc    [DEPTH];
  logic                  r_taken [DEPTH];
  logic [INDEX_BITS-1:0] r_index [DEPTH];
  logic                  r_mispredict;

  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_ready;
  logic          w_accept;
  logic          w_train;
  logic          w_push;
  logic          w_mis;
  logic [AW-1:0] w_head;
  logic [AW-1:0] w_tail;

  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_head   = r_rptr[AW-1:0];
  assign w_tail   = r_wptr[AW-1:0];
  assign w_pop    = !w_empty && upd_ready_i;
  // A full queue still accepts when the head drains in the same cycle.
  assign w_ready  = !w_full || w_pop;
  assign w_accept = res_valid_i && w_ready;
  // Debug-mode branches complete the handshake but never train the predictor.
  assign w_train  = w_accept && !debug_mode_i;
  // A flush discards whatever is accepted alongside it.
  assign w_push   = w_train && !flush_bp_i;
  assign w_mis    = w_train && (res_taken_i != res_pred_taken_i);

  // Read/write pointer update; flush returns both to the origin.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (flush_bp_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Entry storage; contents are only observed through a valid head so no reset.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_pc[w_tail]    <= res_pc_i;
      r_taken[w_tail] <= res_taken_i;
      r_index[w_tail] <= res_index_i;
    end
  end

  // One-cycle mispredict pulse, independent of queue drain and flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_mispredict <= 1'b0;
    else         r_mispredict <= w_mis;
  end

  assign res_ready_o  = w_ready;
  assign upd_valid_o  = !w_empty;
  // Head data is gated so outputs read zero while the queue is empty.
  assign upd_pc_o     = w_empty ? '0   : r_pc[w_head];
  assign upd_taken_o  = w_empty ? 1'b0 : r_taken[w_head];
  assign upd_index_o  = w_empty ? '0   : r_index[w_head];
  assign mispredict_o = r_mispredict;

`ifdef BHT_UPDATE_QUEUE_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;

  // Saturating statistics; only reset clears them, flush does not.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_train) r_branch_cnt  <= sat_inc(r_branch_cnt);
      if (w_mis)   r_mispred_cnt <= sat_inc(r_mispred_cnt);
    end
  end

  assign branch_cnt_o  = r_branch_cnt;
  assign mispred_cnt_o = r_mispred_cnt;
`else
  assign branch_cnt_o  = '0;
  assign mispred_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bht_update_queue.sv
// Testbench for bht_update_queue: vector table plus queue-based scoreboard.
module tb_bht_update_queue;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             flush_bp_i;
  logic             debug_mode_i;
  logic             res_valid_i;
  logic             res_ready_o;
  logic [63:0]      res_pc_i;
  logic             res_taken_i;
  logic             res_pred_taken_i;
  logic [8:0]       res_index_i;
  logic             upd_valid_o;
  logic             upd_ready_i;
  logic [63:0]      upd_pc_o;
  logic             upd_taken_o;
  logic [8:0]       upd_index_o;
  logic             mispredict_o;
  logic [CNT_W-1:0] mispred_cnt_o;
  logic [CNT_W-1:0] branch_cnt_o;

  bht_update_queue #(.VLEN(64), .INDEX_BITS(9), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_bp_i(flush_bp_i), .debug_mode_i(debug_mode_i),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o), .res_pc_i(res_pc_i),
    .res_taken_i(res_taken_i), .res_pred_taken_i(res_pred_taken_i), .res_index_i(res_index_i),
    .upd_valid_o(upd_valid_o), .upd_ready_i(upd_ready_i), .upd_pc_o(upd_pc_o),
    .upd_taken_o(upd_taken_o), .upd_index_o(upd_index_o), .mispredict_o(mispredict_o),
    .mispred_cnt_o(mispred_cnt_o), .branch_cnt_o(branch_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [63:0] pc;
    logic        tk;
    logic [8:0]  idx;
  } ent_t;

  typedef struct {
    logic        v;
    logic [63:0] pc;
    logic        tk;
    logic        pr;
    logic [8:0]  idx;
    logic        dbg;
    logic        rdy;
    logic        fl;
    int          exp_rdy;
  } vec_t;

  ent_t sb[$];
  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   m_bc   = 0;
  int   m_mc   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [63:0] pc, input logic tk, input logic pr,
                     input logic [8:0] idx, input logic dbg, input logic rdy, input logic fl,
                     input int exp_rdy);
    vec_t r;
    r.v = v; r.pc = pc; r.tk = tk; r.pr = pr; r.idx = idx;
    r.dbg = dbg; r.rdy = rdy; r.fl = fl; r.exp_rdy = exp_rdy;
    tbl.push_back(r);
  endtask

  // One clock of stimulus with scoreboard checks; starts and ends 1 after posedge.
  task automatic drive_cycle(input logic v, input logic [63:0] pc, input logic tk,
                             input logic pr, input logic [8:0] idx, input logic dbg,
                             input logic rdy, input logic fl, input int exp_rdy);
    int   n;
    logic m_pop, m_ready, m_acc, exp_mis;
    ent_t e;
    res_valid_i = v; res_pc_i = pc; res_taken_i = tk; res_pred_taken_i = pr;
    res_index_i = idx; debug_mode_i = dbg; upd_ready_i = rdy; flush_bp_i = fl;
    #1;
    n = sb.size();
    chk("upd_valid", upd_valid_o, n > 0);
    if (n > 0) begin
      chk("upd_pc", upd_pc_o, sb[0].pc);
      chk("upd_taken", upd_taken_o, sb[0].tk);
      chk("upd_index", upd_index_o, sb[0].idx);
    end else begin
      chk("upd_pc_empty", upd_pc_o, 0);
    end
    m_pop   = (n > 0) && rdy;
    m_ready = (n < DEPTH) || m_pop;
    m_acc   = v && m_ready;
    chk("res_ready", res_ready_o, m_ready);
    if (exp_rdy >= 0) chk("res_ready_tbl", res_ready_o, exp_rdy[0]);
    @(posedge clk_i);
    if (fl) begin
      sb.delete();
    end else begin
      if (m_pop) void'(sb.pop_front());
      if (m_acc && !dbg) begin
        e.pc = pc; e.tk = tk; e.idx = idx;
        sb.push_back(e);
      end
    end
    exp_mis = m_acc && !dbg && (tk != pr);
`ifdef BHT_UPDATE_QUEUE_STATS_EN
    if (m_acc && !dbg) begin
      if (m_bc < CMAX) m_bc++;
      if (tk != pr && m_mc < CMAX) m_mc++;
    end
`endif
    #1;
    chk("mispredict", mispredict_o, exp_mis);
    chk("branch_cnt", branch_cnt_o, m_bc);
    chk("mispred_cnt", mispred_cnt_o, m_mc);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_ni = 1'b0; flush_bp_i = 0; debug_mode_i = 0; res_valid_i = 0; res_pc_i = '0;
    res_taken_i = 0; res_pred_taken_i = 0; res_index_i = '0; upd_ready_i = 0;

    // Single branch, then drain.
    add(1, 64'h8000_0010, 1, 1, 9'h05, 0, 1, 0, 1);
    add(0, 64'h0, 0, 0, 9'h00, 0, 1, 0, 1);
    add(0, 64'h0, 0, 0, 9'h00, 0, 0, 0, 1);
    // Fill with predictor stalled; fifth push is refused.
    for (int i = 0; i < 5; i++) add(1, 64'h100 + 64'(i * 16), i[0], i[0], 9'(i + 16), 0, 0, 0, (i < 4) ? 1 : 0);
    for (int i = 0; i < 4; i++) add(0, 64'h0, 0, 0, 9'h00, 0, 1, 0, 1);
    add(0, 64'h0, 0, 0, 9'h00, 0, 1, 0, 1);
    // Full queue with simultaneous push and pop across pointer wrap.
    for (int i = 0; i < 4; i++) add(1, 64'h200 + 64'(i * 16), ~i[0], ~i[0], 9'(i + 32), 0, 0, 0, 1);
    add(1, 64'h2FF, 0, 0, 9'h1FE, 0, 0, 0, 0);
    add(1, 64'h240, 1, 1, 9'h024, 0, 1, 0, 1);
    add(1, 64'h250, 0, 0, 9'h025, 0, 1, 0, 1);
    add(1, 64'h2EE, 0, 0, 9'h1EE, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 64'h0, 0, 0, 9'h00, 0, 1, 0, 1);
    add(0, 64'h0, 0, 0, 9'h00, 0, 1, 0, 1);
    // Mispredicted branch.
    add(1, 64'h300, 0, 1, 9'h1FF, 0, 1, 0, 1);
    add(0, 64'h0, 0, 0, 9'h00, 0, 1, 0, 1);
    add(0, 64'h0, 0, 0, 9'h00, 0, 1, 0, 1);
    // Debug mode: handshake only.
    add(1, 64'h400, 1, 1, 9'h040, 1, 1, 0, 1);
    add(1, 64'h410, 0, 1, 9'h041, 1, 1, 0, 1);
    add(1, 64'h420, 1, 0, 9'h042, 1, 0, 0, 1);
    add(0, 64'h0, 0, 0, 9'h00, 0, 1, 0, 1);
    // Flush with three queued entries; accept in flush cycle is discarded.
    for (int i = 0; i < 3; i++) add(1, 64'h500 + 64'(i * 16), 1, 1, 9'(i + 80), 0, 0, 0, 1);
    add(1, 64'h5FF, 1, 0, 9'h05F, 0, 0, 1, 1);
    add(0, 64'h0, 0, 0, 9'h00, 0, 0, 0, 1);
    add(1, 64'h600, 0, 0, 9'h060, 0, 0, 0, 1);
    add(0, 64'h0, 0, 0, 9'h00, 0, 1, 0, 1);
    add(0, 64'h0, 0, 0, 9'h00, 0, 1, 0, 1);

    // Reset state.
    #12;
    chk("rst_upd_valid", upd_valid_o, 0);
    chk("rst_res_ready", res_ready_o, 1);
    chk("rst_mispredict", mispredict_o, 0);
    chk("rst_upd_pc", upd_pc_o, 0);
    chk("rst_branch_cnt", branch_cnt_o, 0);
    chk("rst_mispred_cnt", mispred_cnt_o, 0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    foreach (tbl[i])
      drive_cycle(tbl[i].v, tbl[i].pc, tbl[i].tk, tbl[i].pr, tbl[i].idx,
                  tbl[i].dbg, tbl[i].rdy, tbl[i].fl, tbl[i].exp_rdy);

    // Counter saturation with a back-to-back stream of mispredicts.
    for (int i = 0; i < 18; i++) drive_cycle(1, 64'h700 + 64'(i), 0, 1, 9'(i), 0, 1, 0, 1);
    drive_cycle(0, 64'h0, 0, 0, 9'h00, 0, 1, 0, 1);
`ifdef BHT_UPDATE_QUEUE_STATS_EN
    chk("sat_branch_cnt", branch_cnt_o, CMAX);
    chk("sat_mispred_cnt", mispred_cnt_o, CMAX);
`else
    chk("off_branch_cnt", branch_cnt_o, 0);
    chk("off_mispred_cnt", mispred_cnt_o, 0);
`endif

    // Asynchronous reset in the middle of operation.
    drive_cycle(1, 64'h800, 1, 0, 9'h080, 0, 0, 0, 1);
    drive_cycle(1, 64'h810, 1, 1, 9'h081, 0, 0, 0, 1);
    res_valid_i = 0;
    rst_ni = 1'b0;
    #1;
    chk("arst_upd_valid", upd_valid_o, 0);
    chk("arst_res_ready", res_ready_o, 1);
    chk("arst_mispredict", mispredict_o, 0);
    chk("arst_upd_pc", upd_pc_o, 0);
    chk("arst_branch_cnt", branch_cnt_o, 0);
    chk("arst_mispred_cnt", mispred_cnt_o, 0);
    rst_ni = 1'b1;
    #1;
    sb.delete(); m_bc = 0; m_mc = 0;
    drive_cycle(1, 64'h900, 0, 1, 9'h090, 0, 0, 0, 1);
    drive_cycle(0, 64'h0, 0, 0, 9'h00, 0, 1, 0, 1);
    drive_cycle(0, 64'h0, 0, 0, 9'h00, 0, 1, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
